// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with 1-cycle registered reads, write-first bypass, per-register pending scoreboard and a one-register-per-cycle clear sweep
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_pending,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  input  logic                 clr_req,
  output logic                 busy
);
  typedef enum logic {IDLE, CLEAR} state_t;
  localparam logic [NREG-1:0] ZMASK = {{(NREG-1){1'b1}}, ZERO_REG == 0};
  state_t                 state;
  logic [AW-1:0]          cnt;
  logic [WIDTH-1:0]       regs [NREG];
  logic [NREG-1:0]        pending, pend_clr, pend_nxt;
  logic                   wr_acc, we;
  logic [AW-1:0]          wa;
  logic [WIDTH-1:0]       wd;
  logic [NRD*WIDTH-1:0]   rd_nxt;
  logic [NRD-1:0]         rp_nxt;
  assign busy   = state == CLEAR;
  assign wr_acc = wr_en && !busy && !(ZERO_REG != 0 && wr_addr == '0);
  assign we     = wr_acc || busy;
  assign wa     = busy ? cnt : wr_addr;
  assign wd     = busy ? '0 : wr_data;
  always_comb begin
    pend_clr = pending & ~(wr_acc ? NREG'(1) << wr_addr : '0);
    pend_nxt = (!busy && clr_req) ? '0 : (pend_clr | ((sb_set && !busy) ? NREG'(1) << sb_addr : '0)) & ZMASK;
    rd_nxt   = '0;
    rp_nxt   = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_nxt[i*WIDTH +: WIDTH] = (ZERO_REG != 0 && rd_addr[i*AW +: AW] == '0) ? '0 :
                                 (we && wa == rd_addr[i*AW +: AW]) ? wd : regs[rd_addr[i*AW +: AW]];
      rp_nxt[i] = pend_clr[rd_addr[i*AW +: AW]];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pending    <= '0;
      rd_data    <= '0;
      rd_pending <= '0;
      for (int k = 0; k < NREG; k++) regs[k] <= '0;
    end else begin
      if (we) regs[wa] <= wd;
      pending    <= pend_nxt;
      rd_data    <= rd_nxt;
      rd_pending <= rp_nxt;
      cnt        <= busy ? cnt + 1'b1 : '0;
      state      <= busy ? (cnt == AW'(NREG - 1) ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
    end
  end
endmodule
